pwm_capture: RTL and testbench

- Receive-side counterpart of the 20 kHz PWM chain: measures an incoming PWM waveform instead of generating one.
- Signal sources: feedback from the PWM output pin, or an external PWM-style sensor or servo signal.
- Synchronises and deglitches the input, then measures high time and period in system-clock cycles.
- Reports each completed period with a one-cycle valid strobe and flags a stuck input (0 % or 100 % duty, or lost signal) with a timeout.

---
 rtl/pwm_capture.sv | 179 +++++++++++++++++
 tb/tb_pwm_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: synchronises and deglitches pwm_in, then measures high time and period
// in clkin cycles, with a valid strobe per period and a timeout for a stuck or missing signal.
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FILT    = 2,
  parameter int unsigned TIMEOUT = 20000
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam int unsigned      FiltW      = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [FiltW-1:0] FiltLast   = FiltW'(FILT - 1);
  localparam logic [CNT_W-1:0] BlankLast  = CNT_W'(FILT + 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [1:0] {StBlank, StWaitRise, StMeasHigh, StMeasLow} state_e;

  state_e state_q, state_d;

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [FiltW-1:0] fcnt_q, fcnt_d;
  logic             rise, fall, tmo_hit;

  logic [CNT_W-1:0] counter_q, counter_d, counter_inc;
  logic [CNT_W-1:0] hi_latch_q, hi_latch_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;

  // Input path: two-flop synchroniser followed by the persistence filter.
  always_ff @(posedge clkin) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Any sample agreeing with the filtered level restarts the persistence count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FiltLast) begin
        filt_d = ~filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

  // Edges take precedence over a timeout landing in the same cycle.
  assign tmo_hit     = ~timeout_q & ~(rise | fall) & (counter_q >= TimeoutVal);
  assign counter_inc = (counter_q == CntMax) ? counter_q : counter_q + CntOne;

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= StBlank;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank: begin
        if (counter_q == BlankLast) state_d = StWaitRise;
      end
      StWaitRise: begin
        if (rise) state_d = StMeasHigh;
      end
      StMeasHigh: begin
        if (fall)         state_d = StMeasLow;
        else if (tmo_hit) state_d = StWaitRise;
      end
      StMeasLow: begin
        if (rise)         state_d = StMeasHigh;
        else if (tmo_hit) state_d = StWaitRise;
      end
      default: state_d = StBlank;
    endcase
  end

  always_comb begin
    counter_d    = counter_inc;
    hi_latch_d   = hi_latch_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;
    stuck_d      = stuck_q;
    unique case (state_q)
      StBlank: begin
        counter_d = (counter_q == BlankLast) ? '0 : counter_inc;
      end
      StWaitRise: begin
        if (rise) begin
          counter_d = CntOne;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          stuck_d   = filt_q;
          counter_d = '0;
        end
      end
      StMeasHigh: begin
        if (fall) begin
          hi_latch_d = counter_q;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          stuck_d   = filt_q;
          counter_d = '0;
        end
      end
      StMeasLow: begin
        if (rise) begin
          high_cnt_d   = hi_latch_q;
          period_cnt_d = counter_q;
          valid_d      = 1'b1;
          timeout_d    = 1'b0;
          counter_d    = CntOne;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          stuck_d   = filt_q;
          counter_d = '0;
        end
      end
      default: counter_d = '0;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      counter_q    <= '0;
      hi_latch_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      hi_latch_q   <= hi_latch_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      stuck_q      <= stuck_d;
    end
  end

  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: default instance plus a TIMEOUT=5000 instance sharing the
// stimulus to exercise the edge-versus-timeout collision.
module tb_pwm_capture;

  logic        clkin = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [15:0] high_cnt, period_cnt, high2, period2;
  logic        valid, timeout, stuck_level;
  logic        valid2, timeout2, stuck2;

  int n_checks = 0;
  int n_errors = 0;

  int cyc          = 0;
  int vcnt         = 0;
  int first_vcyc   = 0;
  int last_vcyc    = 0;
  int prev_vcyc    = 0;
  int last_high    = 0;
  int last_period  = 0;
  int v2cnt        = 0;
  int last_high2   = 0;
  int last_period2 = 0;
  int tmo_rise_cyc = 0;
  logic tmo_prev   = 1'b0;

  int k2, ks, vb;

  pwm_capture dut (
    .clkin      (clkin),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .timeout    (timeout),
    .stuck_level(stuck_level)
  );

  pwm_capture #(.TIMEOUT(5000)) dut2 (
    .clkin      (clkin),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high2),
    .period_cnt (period2),
    .valid      (valid2),
    .timeout    (timeout2),
    .stuck_level(stuck2)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  always @(negedge clkin) begin
    if (valid === 1'b1) begin
      vcnt++;
      prev_vcyc   = last_vcyc;
      last_vcyc   = cyc;
      if (vcnt == 1) first_vcyc = cyc;
      last_high   = int'(high_cnt);
      last_period = int'(period_cnt);
    end
    if (valid2 === 1'b1) begin
      v2cnt++;
      last_high2   = int'(high2);
      last_period2 = int'(period2);
    end
    if (timeout === 1'b1 && tmo_prev !== 1'b1) tmo_rise_cyc = cyc;
    tmo_prev = timeout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic pwm_period(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high"},   32'(high_cnt),    0);
    check({tag, "_period"}, 32'(period_cnt),  0);
    check({tag, "_valid"},  32'(valid),       0);
    check({tag, "_tmo"},    32'(timeout),     0);
    check({tag, "_stuck"},  32'(stuck_level), 0);
  endtask

  initial begin
    pwm_in = 1'b0;
    rst    = 1'b1;
    repeat (3) @(posedge clkin);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Normal measurement: 1250 high, 5000 period; four rises give three valids.
    drive(1'b0, 100);
    pwm_period(1250, 3750);
    k2 = cyc;
    repeat (3) pwm_period(1250, 3750);
    check("norm_vcnt",    vcnt, 3);
    check("norm_high",    last_high, 1250);
    check("norm_period",  last_period, 5000);
    check("norm_gap",     last_vcyc - prev_vcyc, 5000);
    check("norm_latency", first_vcyc - k2, 4);
    check("norm_tmo",     32'(timeout), 0);
    check("coll_vcnt",    v2cnt, 3);
    check("coll_high",    last_high2, 1250);
    check("coll_period",  last_period2, 5000);
    check("coll_tmo",     32'(timeout2), 0);

    // 1-cycle low glitch inside the high phase is swallowed.
    drive(1'b1, 600);
    drive(1'b0, 1);
    drive(1'b1, 649);
    drive(1'b0, 3750);
    drive(1'b1, 600);
    check("glitch1_vcnt",   vcnt, 5);
    check("glitch1_high",   last_high, 1250);
    check("glitch1_period", last_period, 5000);
    // 2-cycle low pulse is a real fall and rise.
    drive(1'b0, 2);
    drive(1'b1, 648);
    check("glitch2_vcnt",   vcnt, 6);
    check("glitch2_high",   last_high, 600);
    check("glitch2_period", last_period, 602);
    drive(1'b0, 3750);
    drive(1'b1, 1250);
    check("after_glitch_high",   last_high, 648);
    check("after_glitch_period", last_period, 4398);
    drive(1'b0, 3750);

    // Stuck high: timeout 20000 cycles after the accepted rise.
    ks = cyc;
    drive(1'b1, 20100);
    check("stuck_tmo",     32'(timeout), 1);
    check("stuck_level",   32'(stuck_level), 1);
    check("stuck_tmo_cyc", tmo_rise_cyc - ks, 20004);
    check("stuck_high",    32'(high_cnt), 1250);
    check("stuck_period",  32'(period_cnt), 5000);
    vb = vcnt;
    drive(1'b0, 500);
    drive(1'b1, 1250);
    check("resume_tmo_held", 32'(timeout), 1);
    drive(1'b0, 3750);
    drive(1'b1, 100);
    check("resume_vcnt",   vcnt, vb + 1);
    check("resume_tmo",    32'(timeout), 0);
    check("resume_high",   32'(high_cnt), 1250);
    check("resume_period", 32'(period_cnt), 5000);

    // Reset released with pwm_in already high: no false rise.
    pwm_in = 1'b1;
    rst    = 1'b1;
    repeat (3) @(posedge clkin);
    #1;
    rst = 1'b0;
    vb  = vcnt;
    drive(1'b1, 1000);
    check("rsthigh_vcnt", vcnt, vb);
    check("rsthigh_tmo",  32'(timeout), 0);
    drive(1'b0, 500);
    pwm_period(1250, 3750);
    drive(1'b1, 100);
    check("rsthigh_first_vcnt", vcnt, vb + 1);
    check("rsthigh_high",       32'(high_cnt), 1250);
    check("rsthigh_period",     32'(period_cnt), 5000);

    // Reset during MEAS_LOW discards the partial period.
    drive(1'b1, 1150);
    drive(1'b0, 200);
    rst = 1'b1;
    @(posedge clkin);
    #1;
    check_zero("midrst");
    rst = 1'b0;
    vb  = vcnt;
    drive(1'b0, 300);
    drive(1'b1, 1250);
    check("midrst_novalid", vcnt, vb);
    drive(1'b0, 3750);
    drive(1'b1, 100);
    check("midrst_vcnt",   vcnt, vb + 1);
    check("midrst_high",   32'(high_cnt), 1250);
    check("midrst_period", 32'(period_cnt), 5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
